// File: rtl/apb_pkg.sv
// Shared types and constants for the arbitrated APB master.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_t;

    localparam int AW_DEF = 32;
    localparam int DW_DEF = 32;

    // Wait counter must hold the value TIMEOUT itself.
    function automatic int cnt_width(input int timeout);
        return (timeout < 2) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/apb_rr_arbiter.sv
// Round-robin pick among requesters, starting just after the last grant.
// Latency: purely combinational, zero cycles.
// Backpressure: none; caller decides when the grant is taken.
module apb_rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   gnt_idx,
    output logic            gnt_vld
);

    always_comb begin
        int idx;
        idx     = 0;
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!gnt_vld && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_idx  = IW'(idx);
                gnt_vld  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/apb_master_arb.sv
// Arbitrates NREQ single-command requesters onto one APB master port.
// Latency: accept T, SETUP T+1, ACCESS T+2.., response one cycle after the last ACCESS.
// Backpressure: one transfer in flight; req_ready pulses only in IDLE, slave stalls via PREADY.
module apb_master_arb
    import apb_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int AW      = AW_DEF,
    parameter int DW      = DW_DEF,
    parameter int TIMEOUT = 16
) (
    input  logic               PCLK,
    input  logic               PRESET,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ-1:0]    req_write,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]    req_ready,
    output logic [NREQ-1:0]    rsp_valid,
    output logic [DW-1:0]      rsp_rdata,
    output logic               rsp_err,
    output logic               PSEL,
    output logic               PENABLE,
    output logic               PWRITE,
    output logic [AW-1:0]      PADDR,
    output logic [DW-1:0]      PWDATA,
    input  logic               PREADY,
    input  logic [DW-1:0]      PRDATA
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = cnt_width(TIMEOUT);

    apb_state_t     state_q, state_d;
    logic [IW-1:0]  ptr_q, gidx_q;
    logic [CW-1:0]  cnt_q;
    logic [NREQ-1:0] gnt;
    logic [IW-1:0]  gnt_idx;
    logic           gnt_vld;
    logic           timed_out;

    apb_rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
        .req     (req_valid),
        .ptr     (ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    assign timed_out = (cnt_q == CW'(TIMEOUT));

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        rsp_valid = '0;
        PSEL      = 1'b0;
        PENABLE   = 1'b0;
        case (state_q)
            IDLE: begin
                // Keep the accept pulse quiet while reset is held.
                if (gnt_vld && !PRESET) begin
                    req_ready = gnt;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                PSEL    = 1'b1;
                state_d = ACCESS;
            end
            ACCESS: begin
                PSEL    = 1'b1;
                PENABLE = 1'b1;
                if (PREADY || timed_out) state_d = RESP;
            end
            RESP: begin
                rsp_valid[gidx_q] = 1'b1;
                state_d           = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            ptr_q     <= IW'(NREQ - 1);
            gidx_q    <= '0;
            cnt_q     <= '0;
            PADDR     <= '0;
            PWRITE    <= 1'b0;
            PWDATA    <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (gnt_vld) begin
                        ptr_q  <= gnt_idx;
                        gidx_q <= gnt_idx;
                        PADDR  <= req_addr[int'(gnt_idx)*AW +: AW];
                        PWRITE <= req_write[gnt_idx];
                        if (req_write[gnt_idx])
                            PWDATA <= req_wdata[int'(gnt_idx)*DW +: DW];
                    end
                end
                SETUP: begin
                    cnt_q     <= '0;
                    rsp_rdata <= '0;
                    rsp_err   <= 1'b0;
                end
                ACCESS: begin
                    if (PREADY) begin
                        if (!PWRITE) rsp_rdata <= PRDATA;
                    end else if (timed_out) begin
                        rsp_err <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
